prog_seq: RTL and testbench

PROG_SEQ -- requirements
Module: prog_seq

---
 rtl/prog_seq_pkg.sv | 17 +
 rtl/prog_counter.sv | 30 +++
 rtl/prog_seq.sv | 93 +++++++++
 tb/tb_prog_seq.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/prog_seq_pkg.sv
// Shared types and constants for the programmable sequencer and its pc sub-block.
package prog_seq_pkg;
    localparam int PC_W  = 10;
    localparam int CNT_W = 16;
    localparam int IR_W  = 9;

    localparam logic [IR_W-1:0] HALT_OP = 9'h1FF;
    localparam logic [2:0]      CMP_OPC = 3'b000;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_EXEC  = 3'd2,
        ST_MEM   = 3'd3,
        ST_HALT  = 3'd4
    } state_e;
endpackage

// File: rtl/prog_counter.sv
// Program counter: clear, jump or increment (wrapping), otherwise hold.
module prog_counter
    import prog_seq_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load_zero,
    input  logic            advance,
    input  logic            jump,
    input  logic [PC_W-1:0] target,
    output logic [PC_W-1:0] pc
);
    localparam logic [PC_W-1:0] PC_ONE = 1;

    logic [PC_W-1:0] pc_q, pc_d;

    always_comb begin
        pc_d = pc_q;
        if (load_zero)    pc_d = '0;
        else if (jump)    pc_d = target;
        else if (advance) pc_d = pc_q + PC_ONE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pc_q <= '0;
        else        pc_q <= pc_d;
    end

    assign pc = pc_q;
endmodule

// File: rtl/prog_seq.sv
// Fetch/execute/memory sequencer: drives instruction fetch, latches flags on cmp,
// and issues one commit strobe per completed instruction.
module prog_seq
    import prog_seq_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [IR_W-1:0]  instr_rdata,
    input  logic             pc_jmp_en,
    input  logic [PC_W-1:0]  jmp_target,
    input  logic             mem_op,
    input  logic [2:0]       alu_flags,
    output logic [PC_W-1:0]  instr_addr,
    output logic [IR_W-1:0]  ir,
    output logic [2:0]       flags_q,
    output logic             reg_wr_gate,
    output logic             dat_wr_gate,
    output logic             done,
    output logic [CNT_W-1:0] cycle_cnt
);
    localparam logic [CNT_W-1:0] CNT_ONE = 1;

    state_e            state_q, state_d;
    logic [IR_W-1:0]   ir_q, ir_d;
    logic [2:0]        flags_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic restart, in_exec, is_halt, exec_commit, commit, busy;

    assign restart     = start && (state_q == ST_IDLE || state_q == ST_HALT);
    assign in_exec     = (state_q == ST_EXEC);
    assign is_halt     = (ir_q == HALT_OP);
    assign exec_commit = in_exec && !is_halt && !mem_op;
    assign commit      = exec_commit || (state_q == ST_MEM);
    assign busy        = (state_q == ST_FETCH) || in_exec || (state_q == ST_MEM);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE, ST_HALT: if (restart) state_d = ST_FETCH;
            ST_FETCH:         state_d = ST_EXEC;
            ST_EXEC: begin
                if (is_halt)     state_d = ST_HALT;
                else if (mem_op) state_d = ST_MEM;
                else             state_d = ST_FETCH;
            end
            ST_MEM:           state_d = ST_FETCH;
            default:          state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        ir_d    = (state_q == ST_FETCH) ? instr_rdata : ir_q;
        flags_d = flags_q;
        if (restart)                              flags_d = '0;
        else if (in_exec && ir_q[8:6] == CMP_OPC) flags_d = alu_flags;
        cnt_d = cnt_q;
        if (restart)                  cnt_d = '0;
        else if (busy && cnt_q != '1) cnt_d = cnt_q + CNT_ONE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            ir_q    <= '0;
            flags_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            flags_q <= flags_d;
            cnt_q   <= cnt_d;
        end
    end

    // Memory ops defer their commit to MEM so the synchronous data memory has its cycle.
    prog_counter u_pc (
        .clk       (clk),
        .rst_n     (rst_n),
        .load_zero (restart),
        .advance   (commit && !(exec_commit && pc_jmp_en)),
        .jump      (exec_commit && pc_jmp_en),
        .target    (jmp_target),
        .pc        (instr_addr)
    );

    assign ir          = ir_q;
    assign cycle_cnt   = cnt_q;
    assign done        = (state_q == ST_HALT);
    assign reg_wr_gate = commit;
    assign dat_wr_gate = commit;
endmodule

// File: tb/tb_prog_seq.sv
// Scoreboard bench for prog_seq: expected commits/halts are queued up front and
// checked by a negedge monitor; snapshot checks cover reset and hold behaviour.
module tb_prog_seq;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [8:0] instr_rdata;
    logic       pc_jmp_en;
    logic [9:0] jmp_target;
    logic       mem_op;
    logic [2:0] alu_flags;
    logic [9:0] instr_addr;
    logic [8:0] ir;
    logic [2:0] flags_q;
    logic       reg_wr_gate, dat_wr_gate, done;
    logic [15:0] cycle_cnt;

    localparam logic [8:0] ADD  = 9'h041;
    localparam logic [8:0] CMP  = 9'h005;
    localparam logic [8:0] LDR  = 9'h100;
    localparam logic [8:0] STR  = 9'h140;
    localparam logic [8:0] JMPA = 9'h180;  // -> 10'h020
    localparam logic [8:0] JMPB = 9'h181;  // -> 10'h3FF
    localparam logic [8:0] HLT  = 9'h1FF;

    logic [8:0] rom [0:1023];

    always #5 clk = ~clk;

    // Decoder stand-in: cmp reports flags 101, every other op reports 010.
    assign instr_rdata = rom[instr_addr];
    assign pc_jmp_en   = (ir[8:6] == 3'b110);
    assign jmp_target  = ir[0] ? 10'h3FF : 10'h020;
    assign mem_op      = (ir[8:7] == 2'b10);
    assign alu_flags   = (ir[8:6] == 3'b000) ? 3'b101 : 3'b010;

    prog_seq dut (
        .clk(clk), .rst_n(rst_n), .start(start), .instr_rdata(instr_rdata),
        .pc_jmp_en(pc_jmp_en), .jmp_target(jmp_target), .mem_op(mem_op),
        .alu_flags(alu_flags), .instr_addr(instr_addr), .ir(ir), .flags_q(flags_q),
        .reg_wr_gate(reg_wr_gate), .dat_wr_gate(dat_wr_gate), .done(done),
        .cycle_cnt(cycle_cnt)
    );

    typedef struct {
        bit          halt;
        logic [9:0]  pc;
        logic [8:0]  ir;
        logic [2:0]  fl;
        logic [15:0] cnt;
    } ev_t;

    // kind 0: compare all outputs, 1: report expired wait, 2: event queue must be empty
    typedef struct {
        int          kind;
        string       nm;
        logic [9:0]  pc;
        logic [8:0]  ir;
        logic [2:0]  fl;
        logic [15:0] cnt;
        logic        dn;
    } snap_t;

    ev_t   evq [$];
    snap_t snq [$];
    int    checks = 0;
    int    passed = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s actual=%h required=%h", nm, act, exp);
    endtask

    task automatic ec(input logic [9:0] pc, input logic [8:0] i, input logic [2:0] fl, input logic [15:0] cnt);
        ev_t e;
        e.halt = 1'b0; e.pc = pc; e.ir = i; e.fl = fl; e.cnt = cnt;
        evq.push_back(e);
    endtask

    task automatic eh(input logic [9:0] pc, input logic [2:0] fl, input logic [15:0] cnt);
        ev_t e;
        e.halt = 1'b1; e.pc = pc; e.ir = '0; e.fl = fl; e.cnt = cnt;
        evq.push_back(e);
    endtask

    task automatic snap(input int kind, input string nm, input logic [9:0] pc, input logic [8:0] i,
                        input logic [2:0] fl, input logic [15:0] cnt, input logic dn);
        snap_t s;
        s.kind = kind; s.nm = nm; s.pc = pc; s.ir = i; s.fl = fl; s.cnt = cnt; s.dn = dn;
        snq.push_back(s);
    endtask

    // Monitor: owns every comparison and both counters.
    initial begin
        logic  dprev;
        ev_t   e;
        snap_t s;
        dprev = 1'b0;
        forever begin
            @(negedge clk);
            if (reg_wr_gate || dat_wr_gate) begin
                if (evq.size() == 0 || evq[0].halt) begin
                    chk("commit_unexpected", {instr_addr, cycle_cnt}, 64'hFFFF_FFFF);
                end else begin
                    e = evq.pop_front();
                    chk("commit", {instr_addr, ir, flags_q, cycle_cnt, reg_wr_gate, dat_wr_gate},
                        {e.pc, e.ir, e.fl, e.cnt, 2'b11});
                end
            end
            if (done && !dprev) begin
                if (evq.size() == 0 || !evq[0].halt) begin
                    chk("halt_unexpected", {instr_addr, cycle_cnt}, 64'hFFFF_FFFF);
                end else begin
                    e = evq.pop_front();
                    chk("halt", {instr_addr, flags_q, cycle_cnt}, {e.pc, e.fl, e.cnt});
                end
            end
            dprev = done;
            if (snq.size() != 0) begin
                s = snq.pop_front();
                case (s.kind)
                    0: chk(s.nm, {instr_addr, ir, flags_q, cycle_cnt, done, reg_wr_gate, dat_wr_gate},
                           {s.pc, s.ir, s.fl, s.cnt, s.dn, 2'b00});
                    1: chk(s.nm, 64'd0, 64'd1);
                    default: chk(s.nm, 64'(evq.size()), 64'd0);
                endcase
            end
        end
    end

    task automatic load_rom(input logic [8:0] a0, input logic [8:0] a1, input logic [8:0] a2);
        for (int i = 0; i < 1024; i++) rom[i] = HLT;
        rom[0] = a0; rom[1] = a1; rom[2] = a2;
    endtask

    task automatic pulse_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    task automatic wait_halts(input int n, input string nm);
        int   seen, t;
        logic dp;
        seen = 0; t = 0; dp = done;
        while (seen < n && t < 300) begin
            @(negedge clk);
            if (done && !dp) seen++;
            dp = done;
            t++;
        end
        if (seen < n) snap(1, nm, '0, '0, '0, '0, 1'b0);
    endtask

    initial begin
        int t;
        rst_n = 1'b0;
        start = 1'b0;
        load_rom(HLT, HLT, HLT);
        snap(0, "reset_values", 10'h000, 9'h000, 3'b000, 16'd0, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        snap(0, "idle_after_reset", 10'h000, 9'h000, 3'b000, 16'd0, 1'b0);
        repeat (2) @(negedge clk);

        // add, add, HALT: two commits, done after 7 cycles with cnt 6
        load_rom(ADD, ADD, HLT);
        ec(10'h000, ADD, 3'b000, 16'd1);
        ec(10'h001, ADD, 3'b000, 16'd3);
        eh(10'h002, 3'b000, 16'd6);
        pulse_start();
        wait_halts(1, "timeout_add");

        // ldr, str, HALT: commits land in MEM (third cycle of each)
        load_rom(LDR, STR, HLT);
        ec(10'h000, LDR, 3'b000, 16'd2);
        ec(10'h001, STR, 3'b000, 16'd5);
        eh(10'h002, 3'b000, 16'd8);
        pulse_start();
        wait_halts(1, "timeout_mem");

        // cmp then jmp to 0x020; flags 101 must survive jmp and add
        load_rom(CMP, JMPA, HLT);
        rom[10'h020] = ADD;
        ec(10'h000, CMP,  3'b000, 16'd1);
        ec(10'h001, JMPA, 3'b101, 16'd3);
        ec(10'h020, ADD,  3'b101, 16'd5);
        eh(10'h021, 3'b101, 16'd8);
        pulse_start();
        wait_halts(1, "timeout_jmp");

        // jump to 0x3FF, add there wraps pc to 0 where HALT is placed mid-run
        load_rom(JMPB, HLT, HLT);
        rom[10'h3FF] = ADD;
        ec(10'h000, JMPB, 3'b000, 16'd1);
        ec(10'h3FF, ADD,  3'b000, 16'd3);
        eh(10'h000, 3'b000, 16'd6);
        pulse_start();
        t = 0;
        while (instr_addr != 10'h3FF && t < 50) begin @(negedge clk); t++; end
        if (instr_addr != 10'h3FF) snap(1, "timeout_wrap_reach", '0, '0, '0, '0, 1'b0);
        rom[0] = HLT;
        wait_halts(1, "timeout_wrap");

        // start held high: HALT restarts with flags and count cleared
        load_rom(CMP, HLT, HLT);
        ec(10'h000, CMP, 3'b000, 16'd1);
        eh(10'h001, 3'b101, 16'd4);
        ec(10'h000, CMP, 3'b000, 16'd1);
        eh(10'h001, 3'b101, 16'd4);
        @(negedge clk); start = 1'b1;
        wait_halts(2, "timeout_restart");
        start = 1'b0;
        repeat (3) @(negedge clk);
        snap(0, "halt_hold", 10'h001, HLT, 3'b101, 16'd4, 1'b1);
        repeat (2) @(negedge clk);

        // reset asserted in MEM: async clear, no commit, IDLE after release
        load_rom(LDR, HLT, HLT);
        pulse_start();
        t = 0;
        do begin @(posedge clk); #1; t++; end while (cycle_cnt != 16'd2 && t < 20);
        rst_n = 1'b0;
        snap(0, "reset_in_mem", 10'h000, 9'h000, 3'b000, 16'd0, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        snap(0, "idle_after_mem_reset", 10'h000, 9'h000, 3'b000, 16'd0, 1'b0);
        snap(2, "scoreboard_drained", '0, '0, '0, '0, 1'b0);
        repeat (3) @(negedge clk);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
